// File: rtl/mem_responder.sv
// Single-port word memory slave for a valid/ready master with optional wait states,
// out-of-range error reporting and per-class access counters.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [15:0] fetch_count,
  output logic [15:0] read_count,
  output logic [15:0] write_count,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [31:0]     mem [DEPTH_WORDS];

  // Access captured on the edge entering RESP; the array write commits on RESP exit
  // so a reset during RESP drops it.
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic            wr_pend;

  logic [31:0]     offset_c;
  logic            in_range_c;
  logic [AW-1:0]   idx_c;
  logic            enter_resp_c;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside SPAN.
  assign offset_c   = mem_addr - BASE_ADDR;
  assign in_range_c = (offset_c < SPAN);
  assign idx_c      = offset_c[AW+1:2];

  assign enter_resp_c = mem_valid &&
                        (((state == S_IDLE) && !mem_ready && NO_WAIT) ||
                         ((state == S_WAIT) && (wait_cnt == 4'd0)));

  // Control FSM, response outputs and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      mem_ready   <= 1'b0;
      mem_err     <= 1'b0;
      mem_rdata   <= 32'd0;
      busy        <= 1'b0;
      fetch_count <= 16'd0;
      read_count  <= 16'd0;
      write_count <= 16'd0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      wr_pend     <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      busy      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (mem_valid && !mem_ready && !NO_WAIT) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_INIT;
            busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!mem_valid) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
            busy     <= 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (enter_resp_c) begin
        state     <= S_RESP;
        mem_ready <= 1'b1;
        if (in_range_c) begin
          mem_rdata <= mem[idx_c];
          idx_q     <= idx_c;
          wdata_q   <= mem_wdata;
          wstrb_q   <= mem_wstrb;
          wr_pend   <= (mem_wstrb != 4'd0);
          if (mem_instr)
            fetch_count <= fetch_count + 16'd1;
          else if (mem_wstrb != 4'd0)
            write_count <= write_count + 16'd1;
          else
            read_count  <= read_count + 16'd1;
        end else begin
          mem_err   <= 1'b1;
          mem_rdata <= ERR_RDATA;
          wr_pend   <= 1'b0;
        end
      end
    end
  end

  // Byte-strobed array update; no reset so contents survive reset
  always_ff @(posedge clk) begin
    if ((state == S_RESP) && wr_pend) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
